// File: rtl/pool_cu.sv
// pool_cu: sequencer for a non-overlapping max-pool stage. It produces window read addresses, max-datapath strobes, pooled write addresses and start/end handshakes.
// Optional build macro POOL_CU_STALL_COUNT_EN adds the 16-bit stall_cycles output.
module pool_cu #(
  parameter int IFM_SIZE              = 28,
  parameter int IFM_DEPTH             = 6,
  parameter int POOL_SIZE             = 2,
  parameter int IFM_SIZE_NEXT         = IFM_SIZE / POOL_SIZE,
  parameter int ADDRESS_SIZE_IFM      = $clog2(IFM_SIZE * IFM_SIZE),
  parameter int ADDRESS_SIZE_NEXT_IFM = $clog2(IFM_SIZE_NEXT * IFM_SIZE_NEXT),
  parameter int SEL_WIDTH             = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start_from_previous,
  output logic                             end_to_previous,
  input  logic                             end_from_next,
  output logic                             start_to_next,
  output logic                             ifm_enable_read_current,
  output logic [ADDRESS_SIZE_IFM-1:0]      ifm_address_read_current,
  output logic [SEL_WIDTH-1:0]             ifm_sel_current,
  output logic                             pool_enable,
  output logic                             pool_first,
  output logic                             ifm_enable_write_next,
  output logic [ADDRESS_SIZE_NEXT_IFM-1:0] ifm_address_write_next,
  output logic [SEL_WIDTH-1:0]             ifm_sel_next
`ifdef POOL_CU_STALL_COUNT_EN
  ,
  output logic [15:0]                      stall_cycles
`endif
);
  localparam int PW = (POOL_SIZE > 1) ? $clog2(POOL_SIZE) : 1;
  localparam int WW = (IFM_SIZE_NEXT > 1) ? $clog2(IFM_SIZE_NEXT) : 1;
  localparam logic [PW-1:0]        P_LAST = PW'(POOL_SIZE - 1);
  localparam logic [WW-1:0]        W_LAST = WW'(IFM_SIZE_NEXT - 1);
  localparam logic [SEL_WIDTH-1:0] D_LAST = SEL_WIDTH'(IFM_DEPTH - 1);

  typedef enum logic [1:0] {IDLE, READ, FLUSH, DONE} state_t;

  state_t               state_q, state_d;
  logic                 pending_q, pending_d;
  logic                 out_free_q, out_free_d;
  logic                 flush_q, flush_d;
  logic [PW-1:0]        dc_q, dc_d, dr_q, dr_d;
  logic [WW-1:0]        wc_q, wc_d, wr_q, wr_d;
  logic [SEL_WIDTH-1:0] depth_q, depth_d;
  logic                 go_read;
  logic                 reading, win_first, win_last;

  // Handshake: start_from_previous is a one-cycle pulse latched into pending_q;
  // start_to_next is a one-cycle pulse raised only in DONE while end_from_next is high.
  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q | start_from_previous;
    out_free_d    = out_free_q;
    flush_d       = 1'b0;
    dc_d          = dc_q;
    dr_d          = dr_q;
    wc_d          = wc_q;
    wr_d          = wr_q;
    depth_d       = depth_q;
    go_read       = 1'b0;
    start_to_next = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q && out_free_q) begin
          state_d    = READ;
          go_read    = 1'b1;
          pending_d  = start_from_previous;
          out_free_d = 1'b0;
        end
      end
      READ: begin
        dc_d = dc_q + PW'(1);
        if (dc_q == P_LAST) begin
          dc_d = '0;
          dr_d = dr_q + PW'(1);
          if (dr_q == P_LAST) begin
            dr_d = '0;
            wc_d = wc_q + WW'(1);
            if (wc_q == W_LAST) begin
              wc_d = '0;
              wr_d = wr_q + WW'(1);
              if (wr_q == W_LAST) begin
                wr_d    = '0;
                depth_d = depth_q + SEL_WIDTH'(1);
                if (depth_q == D_LAST) begin
                  depth_d = '0;
                  state_d = FLUSH;
                end
              end
            end
          end
        end
      end
      FLUSH: begin
        flush_d = 1'b1;
        if (flush_q) state_d = DONE;
      end
      DONE: begin
        if (end_from_next) begin
          start_to_next = 1'b1;
          out_free_d    = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign reading   = (state_q == READ);
  assign win_first = reading && (dr_q == '0) && (dc_q == '0);
  assign win_last  = reading && (dr_q == P_LAST) && (dc_q == P_LAST);

  assign ifm_enable_read_current  = reading;
  assign ifm_sel_current          = depth_q;
  assign ifm_address_read_current = ADDRESS_SIZE_IFM'((int'(wr_q) * POOL_SIZE + int'(dr_q)) * IFM_SIZE
                                                      + int'(wc_q) * POOL_SIZE + int'(dc_q));

  // Write strobe is two stages behind the window's last read: one for memory latency, one for the max register.
  logic                             wl1_q;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] waddr1_q;
  logic [SEL_WIDTH-1:0]             wsel1_q;
  logic                             end_prev_q, pool_en_q, pool_first_q;
  logic                             wen_q;
  logic [ADDRESS_SIZE_NEXT_IFM-1:0] waddr_q;
  logic [SEL_WIDTH-1:0]             wsel_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pending_q    <= 1'b0;
      out_free_q   <= 1'b1;
      flush_q      <= 1'b0;
      dc_q         <= '0;
      dr_q         <= '0;
      wc_q         <= '0;
      wr_q         <= '0;
      depth_q      <= '0;
      end_prev_q   <= 1'b0;
      pool_en_q    <= 1'b0;
      pool_first_q <= 1'b0;
      wl1_q        <= 1'b0;
      waddr1_q     <= '0;
      wsel1_q      <= '0;
      wen_q        <= 1'b0;
      waddr_q      <= '0;
      wsel_q       <= '0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      out_free_q   <= out_free_d;
      flush_q      <= flush_d;
      dc_q         <= dc_d;
      dr_q         <= dr_d;
      wc_q         <= wc_d;
      wr_q         <= wr_d;
      depth_q      <= depth_d;
      end_prev_q   <= (state_d != READ);
      pool_en_q    <= reading;
      pool_first_q <= win_first;
      wl1_q        <= win_last;
      if (win_last) begin
        waddr1_q <= ADDRESS_SIZE_NEXT_IFM'(int'(wr_q) * IFM_SIZE_NEXT + int'(wc_q));
        wsel1_q  <= depth_q;
      end
      wen_q   <= wl1_q;
      waddr_q <= waddr1_q;
      wsel_q  <= wsel1_q;
    end
  end

  assign end_to_previous        = end_prev_q;
  assign pool_enable            = pool_en_q;
  assign pool_first             = pool_first_q;
  assign ifm_enable_write_next  = wen_q;
  assign ifm_address_write_next = waddr_q;
  assign ifm_sel_next           = wsel_q;

`ifdef POOL_CU_STALL_COUNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (go_read) begin
      stall_d = '0;
    end else if (((state_q == DONE) && !end_from_next) ||
                 ((state_q == IDLE) && pending_q && !out_free_q)) begin
      if (stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif
endmodule

// File: tb/tb_pool_cu.sv
// Self-checking bench for pool_cu (4x4 maps, depth 2, 2x2 windows), with a read/write scoreboard and directed handshake/reset sequences.
module tb_pool_cu;
  localparam int IFM_SIZE  = 4;
  localparam int IFM_DEPTH = 2;
  localparam int POOL_SIZE = 2;
  localparam int AW        = 4;
  localparam int NAW       = 2;
  localparam int SW        = 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_from_previous = 1'b0;
  logic end_from_next = 1'b0;
  always #5 clk = ~clk;

  logic           end_to_previous, start_to_next, ifm_enable_read_current;
  logic [AW-1:0]  ifm_address_read_current;
  logic [SW-1:0]  ifm_sel_current, ifm_sel_next;
  logic           pool_enable, pool_first, ifm_enable_write_next;
  logic [NAW-1:0] ifm_address_write_next;
`ifdef POOL_CU_STALL_COUNT_EN
  logic [15:0]    stall_cycles;
`endif

  pool_cu #(.IFM_SIZE(IFM_SIZE), .IFM_DEPTH(IFM_DEPTH), .POOL_SIZE(POOL_SIZE)) dut (
    .clk(clk),
    .reset(reset),
    .start_from_previous(start_from_previous),
    .end_to_previous(end_to_previous),
    .end_from_next(end_from_next),
    .start_to_next(start_to_next),
    .ifm_enable_read_current(ifm_enable_read_current),
    .ifm_address_read_current(ifm_address_read_current),
    .ifm_sel_current(ifm_sel_current),
    .pool_enable(pool_enable),
    .pool_first(pool_first),
    .ifm_enable_write_next(ifm_enable_write_next),
    .ifm_address_write_next(ifm_address_write_next),
    .ifm_sel_next(ifm_sel_next)
`ifdef POOL_CU_STALL_COUNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  // per-map read vector table
  typedef struct packed {
    logic [AW-1:0] addr;
    logic          first;
    logic          wlast;
  } rd_vec_t;
  rd_vec_t rd_vec [16];
  int addr_tab [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

  // scoreboard
  logic [SW+AW-1:0]  rd_exp_q [$];
  logic [1:0]        flag_exp_q [$];
  logic [SW+NAW-1:0] wr_exp_q [$];
  int n_checks = 0;
  int n_fail = 0;
  int rd_seen = 0;
  int wr_seen = 0;
  int start_pulses = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_frame();
    for (int d = 0; d < IFM_DEPTH; d++) begin
      for (int i = 0; i < 16; i++) begin
        rd_exp_q.push_back({SW'(d), rd_vec[i].addr});
        flag_exp_q.push_back({rd_vec[i].first, rd_vec[i].wlast});
      end
      for (int j = 0; j < 4; j++) wr_exp_q.push_back({SW'(d), NAW'(j)});
    end
  endtask

  // driver tasks
  task automatic pulse_start();
    @(posedge clk);
    #1 start_from_previous = 1'b1;
    @(posedge clk);
    #1 start_from_previous = 1'b0;
  endtask

  task automatic wait_reads(input int target);
    int k;
    for (k = 0; k < 200; k++) begin
      @(posedge clk);
      if (rd_seen >= target) break;
    end
    check("wait_reads_timeout", 32'(k < 200), 32'd1);
  endtask

  task automatic wait_drain();
    int k;
    for (k = 0; k < 300; k++) begin
      @(posedge clk);
      if (rd_exp_q.size() == 0 && wr_exp_q.size() == 0) break;
    end
    check("drain_timeout", 32'(k < 300), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_end_to_previous"}, 32'(end_to_previous), 32'd0);
    check({tag, "_start_to_next"}, 32'(start_to_next), 32'd0);
    check({tag, "_read_en"}, 32'(ifm_enable_read_current), 32'd0);
    check({tag, "_read_addr"}, 32'(ifm_address_read_current), 32'd0);
    check({tag, "_read_sel"}, 32'(ifm_sel_current), 32'd0);
    check({tag, "_pool_enable"}, 32'(pool_enable), 32'd0);
    check({tag, "_pool_first"}, 32'(pool_first), 32'd0);
    check({tag, "_write_en"}, 32'(ifm_enable_write_next), 32'd0);
    check({tag, "_write_addr"}, 32'(ifm_address_write_next), 32'd0);
    check({tag, "_write_sel"}, 32'(ifm_sel_next), 32'd0);
`ifdef POOL_CU_STALL_COUNT_EN
    check({tag, "_stall"}, 32'(stall_cycles), 32'd0);
`endif
  endtask

  // monitor: compares reads in order and checks strobes against the popped read flags
  logic              rd_h1 = 1'b0, first_h1 = 1'b0, wl_h1 = 1'b0, wl_h2 = 1'b0;
  logic [SW+AW-1:0]  rd_e;
  logic [1:0]        fl_e;
  logic [SW+NAW-1:0] wr_e;

  always @(negedge clk) begin
    if (reset) begin
      rd_exp_q.delete();
      flag_exp_q.delete();
      wr_exp_q.delete();
      rd_h1    <= 1'b0;
      first_h1 <= 1'b0;
      wl_h1    <= 1'b0;
      wl_h2    <= 1'b0;
    end else begin
      if (pool_enable || rd_h1) check("pool_enable", 32'(pool_enable), 32'(rd_h1));
      if (pool_enable && rd_h1) check("pool_first", 32'(pool_first), 32'(first_h1));
      if (ifm_enable_write_next || wl_h2) begin
        check("write_enable", 32'(ifm_enable_write_next), 32'(wl_h2));
        if (ifm_enable_write_next) begin
          wr_seen++;
          check("write_expected", 32'(wr_exp_q.size() > 0), 32'd1);
          if (wr_exp_q.size() > 0) begin
            wr_e = wr_exp_q.pop_front();
            check("write_sel_addr", 32'({ifm_sel_next, ifm_address_write_next}), 32'(wr_e));
          end
        end
      end
      if (start_to_next) start_pulses++;
      wl_h2 <= wl_h1;
      if (ifm_enable_read_current) begin
        rd_seen++;
        check("end_to_previous_in_read", 32'(end_to_previous), 32'd0);
        check("read_expected", 32'(rd_exp_q.size() > 0), 32'd1);
        if (rd_exp_q.size() > 0) begin
          rd_e = rd_exp_q.pop_front();
          fl_e = flag_exp_q.pop_front();
          check("read_sel_addr", 32'({ifm_sel_current, ifm_address_read_current}), 32'(rd_e));
          first_h1 <= fl_e[1];
          wl_h1    <= fl_e[0];
        end else begin
          first_h1 <= 1'b0;
          wl_h1    <= 1'b0;
        end
        rd_h1 <= 1'b1;
      end else begin
        rd_h1    <= 1'b0;
        first_h1 <= 1'b0;
        wl_h1    <= 1'b0;
      end
    end
  end

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  int p0, w0, base;

  initial begin
    for (int i = 0; i < 16; i++) begin
      rd_vec[i].addr  = AW'(addr_tab[i]);
      rd_vec[i].first = (i % 4 == 0);
      rd_vec[i].wlast = (i % 4 == 3);
    end

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    #1 reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("idle_end_to_previous", 32'(end_to_previous), 32'd1);
    check("idle_no_read", 32'(ifm_enable_read_current), 32'd0);

    // frame 1, with a second start remembered during READ
    push_frame();
    pulse_start();
    wait_reads(5);
    pulse_start();
    wait_drain();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("done_hold_no_start", 32'(start_to_next), 32'd0);
      check("done_hold_end_prev", 32'(end_to_previous), 32'd1);
      check("done_hold_no_read", 32'(ifm_enable_read_current), 32'd0);
      @(posedge clk);
    end
`ifdef POOL_CU_STALL_COUNT_EN
    @(negedge clk);
    check("stall_after_done_hold", 32'(stall_cycles), 32'd10);
`endif

    // handoff: exactly one start_to_next pulse, then the pending frame runs
    push_frame();
    p0 = start_pulses;
    @(posedge clk);
    #1 end_from_next = 1'b1;
    repeat (6) @(negedge clk);
    check("handoff_single_pulse", 32'(start_pulses - p0), 32'd1);
    check("second_frame_running", 32'(ifm_enable_read_current), 32'd1);
`ifdef POOL_CU_STALL_COUNT_EN
    check("stall_cleared_on_start", 32'(stall_cycles), 32'd0);
`endif
    wait_drain();
    repeat (3) @(negedge clk);
    check("second_handoff_pulse", 32'(start_pulses - p0), 32'd2);
    check("idle_after_handoff_end_prev", 32'(end_to_previous), 32'd1);

    // reset at read cycle 10 of frame 3
    push_frame();
    base = rd_seen;
    pulse_start();
    wait_reads(base + 10);
    #1 reset = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    w0 = wr_seen;
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    check("no_write_after_reset", 32'(wr_seen - w0), 32'd0);
    check("idle_after_reset_no_read", 32'(ifm_enable_read_current), 32'd0);

    // restart from address 0, map 0
    push_frame();
    pulse_start();
    wait_drain();
    repeat (5) @(negedge clk);
    check("final_end_prev", 32'(end_to_previous), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
